sum_capture_buf: RTL and testbench

//   Downstream result collector for the read_write adder stage. Captures a

---
 rtl/sum_capture_buf.sv | 136 +++++++++++++
 tb/tb_sum_capture_buf.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_capture_buf.sv
// sum_capture_buf
//   Collects a fixed-length run of adder 'sum' results into a small FIFO and
//   streams them out on a valid/ready port. A start/done sequencer frames each
//   capture run.
//
//   Optional feature macro: CAPTURE_CSUM_EN
//     defined     -> adds output 'csum' (modulo-2^16 sum of accepted in_data)
//     not defined -> no csum port, no checksum logic
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous reset, active high
//   start     in   1-cycle pulse, starts a run from IDLE or DONE
//   in_valid  in   in_data valid
//   in_data   in   DW-bit result from the adder stage
//   in_ready  out  block accepts in_data this cycle
//   out_valid out  FIFO not empty
//   out_data  out  FIFO head (first-word-fall-through)
//   out_ready in   consumer pops out_data this cycle
//   count     out  results accepted in the current run
//   overflow  out  sticky, in_valid seen while full during CAPTURE
//   done      out  run complete and FIFO drained
//   csum      out  (CAPTURE_CSUM_EN only) running checksum of accepted data
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | after reset, waiting for start
// CAPTURE | accepting results until NUM_SAMPLES are stored
// DRAIN   | all samples accepted, waiting for FIFO to empty
// DONE    | run complete, FIFO empty, waiting for start

module sum_capture_buf #(
  parameter int DW          = 5,
  parameter int DEPTH       = 8,
  parameter int NUM_SAMPLES = 6,
  parameter int CW          = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          done
`ifdef CAPTURE_CSUM_EN
  ,
  output logic [15:0]   csum
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, occ, occ_nxt;
  logic          full, empty, wr_en, rd_en, start_ok, last_wr;

  // Extra pointer MSB distinguishes full from empty when low bits match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready  = (state == S_CAPTURE) && !full;
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr[AW-1:0]];
  assign done      = (state == S_DONE);

  assign wr_en    = in_valid && in_ready;
  assign rd_en    = out_valid && out_ready;
  assign start_ok = start && ((state == S_IDLE) || (state == S_DONE));
  assign last_wr  = wr_en && (count == CW'(NUM_SAMPLES - 1));
  assign occ      = wr_ptr - rd_ptr;
  assign occ_nxt  = occ + PW'(wr_en) - PW'(rd_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_CAPTURE;
      // The final write always leaves at least one entry, so the DONE branch
      // only matters if that ever changes; it keeps the exit rule uniform.
      S_CAPTURE: if (last_wr) state_nxt = (occ_nxt == '0) ? S_DONE : S_DRAIN;
      S_DRAIN:   if (occ_nxt == '0) state_nxt = S_DONE;
      S_DONE:    if (start) state_nxt = S_CAPTURE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Storage is reset so out_data reads zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= in_data;
        wr_ptr              <= wr_ptr + PW'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      if (start_ok) begin
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (wr_en) count <= count + CW'(1);
        if ((state == S_CAPTURE) && in_valid && !in_ready) overflow <= 1'b1;
      end
    end
  end

`ifdef CAPTURE_CSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           csum <= '0;
    else if (start_ok) csum <= '0;
    else if (wr_en)    csum <= csum + 16'(in_data);
  end
`endif

endmodule

// File: tb/tb_sum_capture_buf.sv
module tb_sum_capture_buf;

  localparam int DW    = 5;
  localparam int DEPTH = 4;
  localparam int NS    = 6;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic [CW-1:0] count;
  logic          overflow;
  logic          done;
`ifdef CAPTURE_CSUM_EN
  logic [15:0]   csum;
`endif

  int checks = 0;
  int errors = 0;

  sum_capture_buf #(.DW(DW), .DEPTH(DEPTH), .NUM_SAMPLES(NS), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .count(count), .overflow(overflow), .done(done)
`ifdef CAPTURE_CSUM_EN
    , .csum(csum)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a run is "active" once started; capture continues
  // while fewer than NS results were taken; the run is done once NS were
  // taken and everything has been consumed.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] pop_log[$];
  bit            m_active;
  int            m_count;
  bit            m_ovf;
  int            m_csum;
  bit            e_capt, e_ready, e_done, e_rd, e_wr;

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      m_active = 0; m_count = 0; m_ovf = 0; m_csum = 0;
    end
    e_capt  = m_active && (m_count < NS);
    e_ready = e_capt && (mq.size() < DEPTH);
    e_done  = m_active && (m_count == NS) && (mq.size() == 0);
    chk("in_ready", 32'(in_ready), 32'(e_ready));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) chk("out_data", 32'(out_data), 32'(mq[0]));
    chk("count", 32'(count), 32'(m_count));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("done", 32'(done), 32'(e_done));
`ifdef CAPTURE_CSUM_EN
    chk("csum", 32'(csum), 32'(m_csum & 16'hffff));
`endif
    if (out_valid && out_ready) pop_log.push_back(out_data);
    if (!rst) begin
      e_rd = (mq.size() != 0) && out_ready;
      e_wr = e_ready && in_valid;
      if (e_rd) void'(mq.pop_front());
      if (e_wr) begin
        mq.push_back(in_data);
        m_count++;
        m_csum = (m_csum + int'(in_data)) & 16'hffff;
      end
      if (e_capt && in_valid && !e_wr) m_ovf = 1;
      if (start && (!m_active || e_done)) begin
        m_active = 1; m_count = 0; m_ovf = 0; m_csum = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 40; i++) begin
      if (done) break;
      tick();
    end
    chk(name, 32'(done), 32'd1);
  endtask

  initial begin
    // 1: reset, no start, data offered
    repeat (3) tick();
    chk("reset_out_data", 32'(out_data), 32'h0);
    rst = 1'b0;
    in_valid = 1'b1; in_data = 5'h07;
    repeat (3) tick();
    chk("t1_in_ready", 32'(in_ready), 32'd0);
    chk("t1_count", 32'(count), 32'd0);
    chk("t1_out_valid", 32'(out_valid), 32'd0);
    chk("t1_overflow", 32'(overflow), 32'd0);
    in_valid = 1'b0;

    // 2: stream 1..6 with consumer always ready
    pop_log.delete();
    out_ready = 1'b1;
    pulse_start();
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1; in_data = DW'(i);
      tick();
    end
    in_valid = 1'b0;
    wait_done("t2_done");
    chk("t2_count", 32'(count), 32'd6);
    chk("t2_pop_n", 32'(pop_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < pop_log.size(); i++)
      chk("t2_order", 32'(pop_log[i]), 32'(i + 1));
`ifdef CAPTURE_CSUM_EN
    chk("t2_csum", 32'(csum), 32'h0015);
`endif

    // 3: consumer stalled, 6 offered into a 4-deep FIFO
    out_ready = 1'b0;
    pulse_start();
    chk("t3_cleared", 32'(done), 32'd0);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = DW'(8 + i);
      tick();
    end
    chk("t3_count", 32'(count), 32'd4);
    chk("t3_in_ready", 32'(in_ready), 32'd0);
    chk("t3_overflow", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    wait_done("t3_done");
    in_valid = 1'b0;

    // 4: half full, simultaneous push/pop for 3 cycles
    pulse_start();
    chk("t4_ovf_clear", 32'(overflow), 32'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = DW'(20 + i);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = DW'(24 + i);
      tick();
    end
    chk("t4_count", 32'(count), 32'd5);
    chk("t4_overflow", 32'(overflow), 32'd0);
    chk("t4_out_valid", 32'(out_valid), 32'd1);
    in_data = 5'h1f;
    tick();
    in_valid = 1'b0;
    wait_done("t4_done");

    // 6: start during CAPTURE is ignored
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = DW'(i + 3);
      tick();
    end
    chk("t6_count2", 32'(count), 32'd2);
    start = 1'b1; in_data = 5'h11;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = DW'(i + 12);
      tick();
    end
    in_valid = 1'b0;
    chk("t6_count", 32'(count), 32'd6);
    wait_done("t6_done");

    // 5: reset during DRAIN with 3 words queued
    pulse_start();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = DW'(i + 1);
      tick();
    end
    out_ready = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("t5_pre_count", 32'(count), 32'd6);
    chk("t5_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    out_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = DW'($urandom_range(0, 31));
      tick();
    end
    in_valid = 1'b0;
    chk("t5_clean_count", 32'(count), 32'd6);
    wait_done("t5_clean_done");

    // Randomized runs against the model
    for (int r = 0; r < 25; r++) begin
      pulse_start();
      for (int c = 0; c < 40; c++) begin
        in_valid  = ($urandom_range(0, 2) != 0);
        in_data   = DW'($urandom_range(0, 31));
        out_ready = ($urandom_range(0, 3) != 0);
        start     = ($urandom_range(0, 15) == 0);
        if (r == 12 && c == 17) rst = 1'b1;
        if (r == 12 && c == 19) rst = 1'b0;
        tick();
      end
      start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      tick();
    end

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
